// File: rtl/iact_csc_pkg.sv
// Shared widths, special CSC words and FSM state encoding for the iact CSC encoder.
package iact_csc_pkg;

  localparam int VALUE_W = 8;
  localparam int ROW_W   = 4;
  localparam int WORD_W  = VALUE_W + ROW_W;

  localparam logic [WORD_W-1:0] EMPTY_COL_WORD = 12'h00F;
  localparam logic [WORD_W-1:0] TERM_WORD      = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    COL_END,
    FRAME_END,
    DONE
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [VALUE_W-1:0] value,
                                                   input logic [ROW_W-1:0]   row);
    return {value, row};
  endfunction

endpackage

// File: rtl/iact_csc_out_reg.sv
// Single-entry output register with valid/ready handshake toward the iact data SRAM.
module iact_csc_out_reg
  import iact_csc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  output logic              space,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_valid,
  input  logic              data_out_ready
);

  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  // A new word may only be loaded when the held one is absent or leaving this cycle.
  assign space = ~vld_q | data_out_ready;

  always_comb begin
    word_d = word_q;
    vld_d  = vld_q;
    if (load) begin
      word_d = load_word;
      vld_d  = 1'b1;
    end else if (data_out_ready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q <= TERM_WORD;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out       = word_q;
  assign data_out_valid = vld_q;

endmodule

// File: rtl/iact_csc_encoder.sv
// Dense column-major iact stream to CSC words {value,row}, with column/frame terminators.
// Optional build macro IACT_CSC_NZ_COUNT_EN adds the nz_count output.
module iact_csc_encoder
  import iact_csc_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [VALUE_W-1:0] dense_in,
  input  logic               dense_in_valid,
  output logic               dense_in_ready,
  input  logic               dense_in_last,
  input  logic               frame_last,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               write_en,
  output logic               frame_done,
  output logic               row_overflow
`ifdef IACT_CSC_NZ_COUNT_EN
  ,
  output logic [10:0]        nz_count
`endif
);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               col_nz_q, col_nz_d;
  logic               col_full_q, col_full_d;
  logic               frame_last_q, frame_last_d;
  logic               term_sent_q, term_sent_d;
  logic               write_en_q, write_en_d;
  logic               frame_done_q, frame_done_d;
  logic               row_overflow_q, row_overflow_d;
`ifdef IACT_CSC_NZ_COUNT_EN
  logic [10:0]        nz_count_q, nz_count_d;
`endif

  logic               space;
  logic               load;
  logic [WORD_W-1:0]  load_word;
  logic               accept;

  assign dense_in_ready = (state_q == ENCODE) & space;
  assign accept         = dense_in_valid & dense_in_ready;

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_nz_d       = col_nz_q;
    col_full_d     = col_full_q;
    frame_last_d   = frame_last_q;
    term_sent_d    = term_sent_q;
    write_en_d     = write_en_q;
    frame_done_d   = 1'b0;
    row_overflow_d = row_overflow_q;
`ifdef IACT_CSC_NZ_COUNT_EN
    nz_count_d     = nz_count_q;
`endif
    load           = 1'b0;
    load_word      = TERM_WORD;

    case (state_q)
      IDLE: begin
        if (dense_in_valid) begin
          state_d    = ENCODE;
          write_en_d = 1'b1;
          row_d      = '0;
          col_nz_d   = 1'b0;
          col_full_d = 1'b0;
`ifdef IACT_CSC_NZ_COUNT_EN
          nz_count_d = '0;
`endif
        end
      end

      ENCODE: begin
        if (accept) begin
          if (dense_in != '0) begin
            load      = 1'b1;
            load_word = pack_word(dense_in, row_q);
            col_nz_d  = 1'b1;
`ifdef IACT_CSC_NZ_COUNT_EN
            nz_count_d = nz_count_q + 11'd1;
`endif
          end
          // col_full_q means the row counter already wrapped past 15 in this column.
          if (col_full_q) row_overflow_d = 1'b1;
          if (dense_in_last) begin
            row_d        = '0;
            col_full_d   = 1'b0;
            frame_last_d = frame_last;
            state_d      = COL_END;
          end else begin
            row_d = row_q + ROW_W'(1);
            if (row_q == '1) col_full_d = 1'b1;
          end
        end
      end

      COL_END: begin
        if (space) begin
          load = 1'b1;
          if (!col_nz_q) begin
            // Empty column: marker first, terminator on the following slot.
            load_word = EMPTY_COL_WORD;
            col_nz_d  = 1'b1;
          end else begin
            load_word   = TERM_WORD;
            col_nz_d    = 1'b0;
            term_sent_d = 1'b0;
            state_d     = frame_last_q ? FRAME_END : ENCODE;
          end
        end
      end

      FRAME_END: begin
        if (!term_sent_q) begin
          if (space) begin
            load        = 1'b1;
            load_word   = TERM_WORD;
            term_sent_d = 1'b1;
          end
        end else if (data_out_ready) begin
          // The second terminator is the only word held, so this is its transfer.
          term_sent_d  = 1'b0;
          write_en_d   = 1'b0;
          frame_done_d = 1'b1;
          state_d      = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_nz_q       <= 1'b0;
      col_full_q     <= 1'b0;
      frame_last_q   <= 1'b0;
      term_sent_q    <= 1'b0;
      write_en_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      row_overflow_q <= 1'b0;
`ifdef IACT_CSC_NZ_COUNT_EN
      nz_count_q     <= '0;
`endif
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_nz_q       <= col_nz_d;
      col_full_q     <= col_full_d;
      frame_last_q   <= frame_last_d;
      term_sent_q    <= term_sent_d;
      write_en_q     <= write_en_d;
      frame_done_q   <= frame_done_d;
      row_overflow_q <= row_overflow_d;
`ifdef IACT_CSC_NZ_COUNT_EN
      nz_count_q     <= nz_count_d;
`endif
    end
  end

  iact_csc_out_reg u_out_reg (
    .clock          (clock),
    .reset          (reset),
    .load           (load),
    .load_word      (load_word),
    .space          (space),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
  );

  assign write_en     = write_en_q;
  assign frame_done   = frame_done_q;
  assign row_overflow = row_overflow_q;
`ifdef IACT_CSC_NZ_COUNT_EN
  assign nz_count     = nz_count_q;
`endif

endmodule

// File: tb/tb_iact_csc_encoder.sv
// Self-checking bench for iact_csc_encoder: directed scenarios plus randomized frames vs a stream model.
module tb_iact_csc_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  dense_in;
  logic        dense_in_valid, dense_in_ready, dense_in_last, frame_last;
  logic [11:0] data_out;
  logic        data_out_valid, data_out_ready;
  logic        write_en, frame_done, row_overflow;
`ifdef IACT_CSC_NZ_COUNT_EN
  logic [10:0] nz_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]  stim_vals[$];
  int          stim_lens[$];
  logic [11:0] exp_q[$];
  logic [11:0] got_q[$];
  int          nz_exp;
  int          fd_cnt = 0;
  int          fd_mark;
  int          we_bad = 0;
  logic        we_at_done = 1'b1;
  bit          gap_en = 0, rdy_rand = 0, rdy_hold_low = 0, abort_drv = 0;

  always #5 clock = ~clock;

  iact_csc_encoder dut (
    .clock          (clock),
    .reset          (reset),
    .dense_in       (dense_in),
    .dense_in_valid (dense_in_valid),
    .dense_in_ready (dense_in_ready),
    .dense_in_last  (dense_in_last),
    .frame_last     (frame_last),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .write_en       (write_en),
    .frame_done     (frame_done),
    .row_overflow   (row_overflow)
`ifdef IACT_CSC_NZ_COUNT_EN
    ,
    .nz_count       (nz_count)
`endif
  );

  // Sink: always ready, random, or held low on request.
  initial begin
    data_out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_hold_low)  data_out_ready = 1'b0;
      else if (rdy_rand) data_out_ready = ($urandom_range(0, 3) != 0);
      else               data_out_ready = 1'b1;
    end
  end

  // Transfers happen at the next rising edge; values are stable at the falling edge.
  always @(negedge clock) begin
    if (data_out_valid && data_out_ready) begin
      got_q.push_back(data_out);
      if (!write_en) we_bad++;
    end
    if (frame_done) begin
      fd_cnt++;
      we_at_done = write_en;
    end
  end

  // Reference stream: nonzero values with row index mod 16, empty marker for
  // all-zero columns, one terminator per column, one extra per frame.
  task automatic build_expected();
    int  k = 0;
    bit  any;
    exp_q.delete();
    nz_exp = 0;
    for (int c = 0; c < stim_lens.size(); c++) begin
      any = 0;
      for (int i = 0; i < stim_lens[c]; i++) begin
        if (stim_vals[k] != 8'h00) begin
          exp_q.push_back({stim_vals[k], 4'(i % 16)});
          nz_exp++;
          any = 1;
        end
        k++;
      end
      if (!any) exp_q.push_back(12'h00F);
      exp_q.push_back(12'h000);
    end
    exp_q.push_back(12'h000);
  endtask

  task automatic drive_frame();
    int k = 0, c = 0, i = 0, budget = 0;
    while (k < stim_vals.size() && !abort_drv && budget < 3000) begin
      @(posedge clock);
      #1;
      if (gap_en && $urandom_range(0, 3) == 0) begin
        dense_in_valid = 1'b0;
      end else begin
        dense_in_valid = 1'b1;
        dense_in       = stim_vals[k];
        dense_in_last  = (i == stim_lens[c] - 1);
        frame_last     = (c == stim_lens.size() - 1);
      end
      @(negedge clock);
      if (dense_in_valid && dense_in_ready) begin
        k++;
        i++;
        if (i == stim_lens[c]) begin
          i = 0;
          c++;
        end
      end
      budget++;
    end
    @(posedge clock);
    #1;
    dense_in_valid = 1'b0;
    checks++;
    if (budget >= 3000) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d of %0d elements", k, stim_vals.size());
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int b = 0; b < 800; b++) begin
      @(negedge clock);
      if (fd_cnt > fd_mark) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic start_frame();
    got_q.delete();
    fd_mark = fd_cnt;
    build_expected();
  endtask

  task automatic test_reset();
    checks += 6;
    if (data_out !== 12'h000)     begin errors++; $display("FAIL reset_data_out: got %h want 000", data_out); end
    if (data_out_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
    if (dense_in_ready !== 1'b0)  begin errors++; $display("FAIL reset_ready: got %b want 0", dense_in_ready); end
    if (write_en !== 1'b0)        begin errors++; $display("FAIL reset_write_en: got %b want 0", write_en); end
    if (frame_done !== 1'b0)      begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    if (row_overflow !== 1'b0)    begin errors++; $display("FAIL reset_overflow: got %b want 0", row_overflow); end
  endtask

  task automatic test_latency();
    bit ok = 0;
    stim_vals = '{8'h09};
    stim_lens = '{1};
    start_frame();
    @(posedge clock);
    #1;
    dense_in = 8'h09; dense_in_last = 1'b1; frame_last = 1'b1; dense_in_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      @(negedge clock);
      if (dense_in_ready) begin ok = 1; break; end
    end
    @(posedge clock);
    #1;
    dense_in_valid = 1'b0;
    @(negedge clock);
    checks += 2;
    if (!ok || data_out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b want 1", data_out_valid); end
    if (data_out !== 12'h090)           begin errors++; $display("FAIL latency_word: got %h want 090", data_out); end
    wait_done(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL latency_done: frame_done not seen, want pulse"); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL latency_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL latency_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_basic();
    bit ok;
    stim_vals = '{8'h00, 8'h05, 8'h00, 8'h07};
    stim_lens = '{4};
    start_frame();
    drive_frame();
    wait_done(ok);
    checks += 4;
    if (!ok)                   begin errors++; $display("FAIL basic_done: frame_done not seen, want pulse"); end
    if (fd_cnt - fd_mark != 1) begin errors++; $display("FAIL basic_pulse: got %0d cycles high want 1", fd_cnt - fd_mark); end
    if (we_at_done !== 1'b0)   begin errors++; $display("FAIL basic_we_done: got %b want 0", we_at_done); end
    if (row_overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b want 0", row_overflow); end
`ifdef IACT_CSC_NZ_COUNT_EN
    checks++;
    if (nz_count !== 11'd2) begin errors++; $display("FAIL basic_nz_count: got %0d want 2", nz_count); end
`endif
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_col();
    bit ok;
    stim_vals = '{8'h03, 8'h00, 8'h00, 8'h00};
    stim_lens = '{2, 2};
    start_frame();
    drive_frame();
    wait_done(ok);
    checks += 2;
    if (!ok)                   begin errors++; $display("FAIL empty_done: frame_done not seen, want pulse"); end
    if (got_q.size() !== 5)    begin errors++; $display("FAIL empty_len: got %0d want 5", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL empty_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit          ok = 0;
    logic [11:0] held;
    stim_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    stim_lens = '{8};
    start_frame();
    fork
      drive_frame();
      begin
        for (int b = 0; b < 50; b++) begin
          @(posedge clock);
          if (got_q.size() >= 2) begin ok = 1; break; end
        end
        rdy_hold_low = 1;
        held = 12'hxxx;
        for (int n = 0; n < 5; n++) begin
          @(negedge clock);
          if (n == 0) held = data_out;
          checks += 3;
          if (data_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", n, data_out_valid); end
          if (data_out !== held)       begin errors++; $display("FAIL bp_stable[%0d]: got %h want %h", n, data_out, held); end
          if (dense_in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", n, dense_in_ready); end
        end
        rdy_hold_low = 0;
      end
    join
    wait_done(ok);
    checks += 2;
    if (!ok)                            begin errors++; $display("FAIL bp_done: frame_done not seen, want pulse"); end
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    stim_vals.delete();
    for (int i = 0; i < 17; i++) stim_vals.push_back(8'h01);
    stim_lens = '{17};
    start_frame();
    drive_frame();
    wait_done(ok);
    checks += 3;
    if (!ok)                   begin errors++; $display("FAIL ovf_done: frame_done not seen, want pulse"); end
    if (row_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", row_overflow); end
    if (got_q.size() !== 19)   begin errors++; $display("FAIL ovf_len: got %0d want 19", got_q.size()); end
    if (got_q.size() > 16) begin
      checks++;
      if (got_q[16] !== 12'h010) begin errors++; $display("FAIL ovf_word17: got %h want 010", got_q[16]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok = 0;
    stim_vals = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98};
    stim_lens = '{8};
    start_frame();
    fork
      drive_frame();
      begin
        for (int b = 0; b < 50; b++) begin
          @(posedge clock);
          if (got_q.size() >= 2) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_mid_wait: got %0d words want 2", got_q.size()); end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks += 6;
        if (data_out !== 12'h000)    begin errors++; $display("FAIL rst_mid_data: got %h want 000", data_out); end
        if (data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", data_out_valid); end
        if (dense_in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", dense_in_ready); end
        if (write_en !== 1'b0)       begin errors++; $display("FAIL rst_mid_we: got %b want 0", write_en); end
        if (frame_done !== 1'b0)     begin errors++; $display("FAIL rst_mid_fd: got %b want 0", frame_done); end
        if (row_overflow !== 1'b0)   begin errors++; $display("FAIL rst_mid_ovf: got %b want 0", row_overflow); end
        abort_drv = 1;
      end
    join
    @(negedge clock);
    reset = 1'b0;
    abort_drv = 0;
    repeat (2) @(negedge clock);
    stim_vals = '{8'h00, 8'h00, 8'h04, 8'h06};
    stim_lens = '{3, 1};
    start_frame();
    drive_frame();
    wait_done(ok);
    checks += 2;
    if (!ok)                            begin errors++; $display("FAIL rst_new_done: frame_done not seen, want pulse"); end
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rst_new_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_new_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int ncols, len;
    gap_en   = 1;
    rdy_rand = 1;
    for (int f = 0; f < 5; f++) begin
      stim_vals.delete();
      stim_lens.delete();
      ncols = $urandom_range(1, 4);
      for (int c = 0; c < ncols; c++) begin
        len = $urandom_range(1, 6);
        stim_lens.push_back(len);
        for (int i = 0; i < len; i++)
          stim_vals.push_back($urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      we_bad = 0;
      start_frame();
      drive_frame();
      wait_done(ok);
      checks += 4;
      if (!ok)                            begin errors++; $display("FAIL rand%0d_done: frame_done not seen, want pulse", f); end
      if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      if (we_bad != 0)                    begin errors++; $display("FAIL rand%0d_we: got %0d transfers with write_en low want 0", f, we_bad); end
      if (row_overflow !== 1'b0)          begin errors++; $display("FAIL rand%0d_ovf: got %b want 0", f, row_overflow); end
`ifdef IACT_CSC_NZ_COUNT_EN
      checks++;
      if (nz_count !== 11'(nz_exp)) begin errors++; $display("FAIL rand%0d_nz: got %0d want %0d", f, nz_count, nz_exp); end
`endif
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word[%0d]: got %h want %h", f, i, got_q[i], exp_q[i]); end
      end
    end
    gap_en   = 0;
    rdy_rand = 0;
  endtask

  initial begin
    reset          = 1'b1;
    dense_in       = 8'h00;
    dense_in_valid = 1'b0;
    dense_in_last  = 1'b0;
    frame_last     = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_latency();
    test_basic();
    test_empty_col();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
